femul_digit: RTL and testbench

Parametrised digit-serial multiplier over GF(2^255−19), successor to the fixed bit-serial field multiplier. It computes out = a·b mod p (or a² in square mode) by consuming DIGIT_W bits of the multiplier per cycle, MSB-first, with on-the-fly folding by 19. It sits between the curve-arithmetic sequencer and the register file. Both sides use valid/ready handshakes, and a tag is carried through unchanged.

---
 rtl/femul_pkg.sv | 22 ++
 rtl/femul_digit_if.sv | 29 ++
 rtl/femul_fold.sv | 23 ++
 rtl/femul_digit.sv | 130 +++++++++++++
 tb/tb_femul_digit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/femul_pkg.sv
// Shared constants, state encoding and digit-count helper for the GF(2^255-19)
// digit-serial multiplier.
package femul_pkg;

  localparam int FE_W   = 255;
  localparam int FOLD_K = 19;

  // p = 2^255 - 19
  localparam logic [FE_W-1:0] P = {{250{1'b1}}, 5'b01101};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FOLD,
    DONE
  } state_t;

  function automatic int num_digits(input int digit_w);
    return (FE_W + digit_w - 1) / digit_w;
  endfunction

endpackage

// File: rtl/femul_digit_if.sv
// Operand/result handshake bundle between the curve sequencer (master) and
// the field multiplier (slave).
interface femul_digit_if #(
  parameter int TAG_W = 4
);
  import femul_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             in_square;
  logic [FE_W-1:0]  in_a;
  logic [FE_W-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [FE_W-1:0]  out_value;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_square, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_value, out_tag
  );

  modport slave (
    input  in_valid, in_square, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_value, out_tag
  );

endinterface

// File: rtl/femul_fold.sv
// Combinational reduction step: returns x[254:0] + 19 * (x >> 255), using
// 2^255 == 19 (mod p).
module femul_fold
  import femul_pkg::*;
#(
  parameter int IN_W  = 256,
  parameter int OUT_W = 256
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y
);

  localparam int HW = IN_W - FE_W;
  localparam int PW = HW + 5;

  logic [HW-1:0] hi;
  logic [PW-1:0] prod;

  assign hi   = x[IN_W-1:FE_W];
  assign prod = PW'(hi) * PW'(FOLD_K);
  assign y    = OUT_W'(x[FE_W-1:0]) + OUT_W'(prod);

endmodule

// File: rtl/femul_digit.sv
// Digit-serial GF(2^255-19) multiplier, MSB-first with per-digit folding.
// Define FEMUL_DIGIT_CANON_EN to reduce the result fully into [0, p).
module femul_digit
  import femul_pkg::*;
#(
  parameter int DIGIT_W = 17,
  parameter int TAG_W   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  femul_digit_if.slave bus
);

  localparam int N    = num_digits(DIGIT_W);
  localparam int B_W  = N * DIGIT_W;
  localparam int AD_W = FE_W + DIGIT_W;
  localparam int T_W  = FE_W + 2 + DIGIT_W;

  state_t state;
  state_t state_next;

  logic             load;
  logic             step;
  logic             finish;

  logic [FE_W-1:0]  a_reg;
  logic [B_W-1:0]   b_reg;
  logic [TAG_W-1:0] tag_reg;
  logic [FE_W:0]    acc;
  logic [8:0]       cnt;
  logic [FE_W-1:0]  value_reg;
  logic [TAG_W-1:0] out_tag_reg;

  logic [DIGIT_W-1:0] digit;
  logic [AD_W-1:0]    ad;
  logic [T_W-1:0]     t;
  logic [FE_W:0]      acc_next;
  logic [FE_W:0]      r1;
  logic [FE_W-1:0]    r2;
  logic [FE_W-1:0]    result;

  assign bus.in_ready  = reset_n & ((state == IDLE) | ((state == DONE) & bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign bus.out_value = value_reg;
  assign bus.out_tag   = out_tag_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == 9'(N - 1)) state_next = FOLD;
      end
      FOLD: begin
        finish     = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        // Retiring and accepting on the same edge keeps the pipe bubble-free
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            load       = 1'b1;
            state_next = RUN;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign digit = b_reg[B_W-1 -: DIGIT_W];
  assign ad    = AD_W'(a_reg) * AD_W'(digit);
  assign t     = T_W'({acc, {DIGIT_W{1'b0}}}) + T_W'(ad);

  femul_fold #(.IN_W(T_W), .OUT_W(FE_W + 1)) u_fold_run (.x(t), .y(acc_next));
  femul_fold #(.IN_W(FE_W + 1), .OUT_W(FE_W + 1)) u_fold_r1 (.x(acc), .y(r1));
  // Second fold always lands below 2^255, so its carry bit is dropped
  femul_fold #(.IN_W(FE_W + 1), .OUT_W(FE_W)) u_fold_r2 (.x(r1), .y(r2));

`ifdef FEMUL_DIGIT_CANON_EN
  assign result = (r2 >= P) ? (r2 - P) : r2;
`else
  assign result = r2;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      tag_reg     <= '0;
      acc         <= '0;
      cnt         <= '0;
      value_reg   <= '0;
      out_tag_reg <= '0;
    end else begin
      if (load) begin
        a_reg   <= bus.in_a;
        b_reg   <= B_W'(bus.in_square ? bus.in_a : bus.in_b);
        tag_reg <= bus.in_tag;
        acc     <= '0;
        cnt     <= '0;
      end else if (step) begin
        acc   <= acc_next;
        b_reg <= b_reg << DIGIT_W;
        cnt   <= cnt + 9'd1;
      end
      if (finish) begin
        value_reg   <= result;
        out_tag_reg <= tag_reg;
      end
    end
  end

endmodule

// File: tb/tb_femul_digit.sv
// Directed self-checking bench for femul_digit at DIGIT_W = 17, 1 and 32.
module tb_femul_digit;
  import femul_pkg::*;

  localparam int TAG_W = 4;
  localparam int N17   = num_digits(17);

  logic clock = 1'b0;
  logic reset_n;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [FE_W-1:0]  all_ones;
  logic [FE_W-1:0]  pm1;
  logic [FE_W-1:0]  held_value;
  logic [TAG_W-1:0] held_tag;
  int               lat;

  always #5 clock = ~clock;

  femul_digit_if #(.TAG_W(TAG_W)) bus   ();
  femul_digit_if #(.TAG_W(TAG_W)) bus1  ();
  femul_digit_if #(.TAG_W(TAG_W)) bus32 ();

  femul_digit #(.DIGIT_W(17), .TAG_W(TAG_W)) dut   (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  femul_digit #(.DIGIT_W(1),  .TAG_W(TAG_W)) dut1  (.clock(clock), .reset_n(reset_n), .bus(bus1.slave));
  femul_digit #(.DIGIT_W(32), .TAG_W(TAG_W)) dut32 (.clock(clock), .reset_n(reset_n), .bus(bus32.slave));

  task automatic checkOutput(input string name, input logic [255:0] observed, input logic [255:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  // (p-1)^2 == 1; without full reduction p+1 is also an acceptable representative
  task automatic checkPm1(input string name, input logic [FE_W-1:0] v);
`ifdef FEMUL_DIGIT_CANON_EN
    checkOutput(name, 256'(v), 256'd1);
`else
    checkOutput(name, 256'((v === 255'd1) || (v === P + 255'd1)), 256'd1);
`endif
  endtask

  task automatic applyStimulus(input logic [FE_W-1:0] a, input logic [FE_W-1:0] b,
                               input logic sq, input logic [TAG_W-1:0] tag);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_square = sq;
    bus.in_tag    = tag;
    bus.in_valid  = 1'b1;
    checkOutput("accept_ready", 256'(bus.in_ready), 256'd1);
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_a      = all_ones;
    bus.in_b      = all_ones;
    bus.in_square = 1'b0;
    bus.in_tag    = '1;
  endtask

  task automatic waitResult(input string name);
    int edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 400) begin
      @(posedge clock);
      #1;
      edges++;
    end
    checkOutput(name, 256'(edges), 256'(N17 + 1));
  endtask

  task automatic retire();
    bus.out_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("retired_idle", 256'({bus.out_valid, bus.in_ready}), 256'b01);
  endtask

  initial begin
    all_ones = '1;
    pm1      = P - 255'd1;
    reset_n  = 1'b0;
    bus.in_valid = 1'b0;   bus.in_square = 1'b0;   bus.in_a = '0;   bus.in_b = '0;   bus.in_tag = '0;   bus.out_ready = 1'b0;
    bus1.in_valid = 1'b0;  bus1.in_square = 1'b0;  bus1.in_a = '0;  bus1.in_b = '0;  bus1.in_tag = '0;  bus1.out_ready = 1'b0;
    bus32.in_valid = 1'b0; bus32.in_square = 1'b0; bus32.in_a = '0; bus32.in_b = '0; bus32.in_tag = '0; bus32.out_ready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_in_ready", 256'(bus.in_ready), 256'd0);
    checkOutput("rst_out_valid", 256'(bus.out_valid), 256'd0);
    checkOutput("rst_out_value", 256'(bus.out_value), 256'd0);
    checkOutput("rst_out_tag", 256'(bus.out_tag), 256'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("post_rst_ready", 256'(bus.in_ready), 256'd1);

    applyStimulus(255'd2, 255'd3, 1'b0, 4'd5);
    waitResult("mul2x3_lat");
    checkOutput("mul2x3_value", 256'(bus.out_value), 256'd6);
    checkOutput("mul2x3_tag", 256'(bus.out_tag), 256'd5);
    retire();

    applyStimulus(all_ones, 255'd1, 1'b0, 4'd3);
    waitResult("ones_lat");
`ifdef FEMUL_DIGIT_CANON_EN
    checkOutput("ones_value", 256'(bus.out_value), 256'd18);
`else
    checkOutput("ones_value", 256'(bus.out_value), 256'(all_ones));
`endif
    checkOutput("ones_tag", 256'(bus.out_tag), 256'd3);
    retire();

    applyStimulus(255'd1 << 128, all_ones, 1'b1, 4'd7);
    waitResult("sq128_lat");
    checkOutput("sq128_value", 256'(bus.out_value), 256'd38);
    checkOutput("sq128_tag", 256'(bus.out_tag), 256'd7);
    retire();

    applyStimulus(255'd0, all_ones, 1'b1, 4'd10);
    waitResult("sq0_lat");
    checkOutput("sq0_value", 256'(bus.out_value), 256'd0);
    checkOutput("sq0_tag", 256'(bus.out_tag), 256'd10);
    retire();

    applyStimulus(pm1, pm1, 1'b0, 4'd12);
    waitResult("pm1_lat");
    checkPm1("pm1_value", bus.out_value);
    checkOutput("pm1_tag", 256'(bus.out_tag), 256'd12);

    held_value = bus.out_value;
    held_tag   = bus.out_tag;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checkOutput("bp_value", 256'(bus.out_value), 256'(held_value));
      checkOutput("bp_tag", 256'(bus.out_tag), 256'(held_tag));
      checkOutput("bp_valid", 256'(bus.out_valid), 256'd1);
      checkOutput("bp_in_ready", 256'(bus.in_ready), 256'd0);
    end

    bus.in_a      = 255'd5;
    bus.in_b      = 255'd7;
    bus.in_tag    = 4'd9;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("b2b_in_ready", 256'(bus.in_ready), 256'd1);
    @(posedge clock);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_a      = all_ones;
    bus.in_b      = all_ones;
    checkOutput("b2b_running", 256'(bus.out_valid), 256'd0);
    waitResult("b2b_lat");
    checkOutput("b2b_value", 256'(bus.out_value), 256'd35);
    checkOutput("b2b_tag", 256'(bus.out_tag), 256'd9);
    retire();

    applyStimulus(pm1, pm1, 1'b0, 4'd6);
    repeat (4) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 256'(bus.out_valid), 256'd0);
    checkOutput("midrst_value", 256'(bus.out_value), 256'd0);
    checkOutput("midrst_tag", 256'(bus.out_tag), 256'd0);
    checkOutput("midrst_in_ready", 256'(bus.in_ready), 256'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    #1;
    applyStimulus(255'd2, 255'd3, 1'b0, 4'd11);
    waitResult("after_rst_lat");
    checkOutput("after_rst_value", 256'(bus.out_value), 256'd6);
    checkOutput("after_rst_tag", 256'(bus.out_tag), 256'd11);
    retire();

    bus1.in_a = pm1;  bus1.in_b = pm1;  bus1.in_tag = 4'd2;  bus1.in_valid = 1'b1;
    bus32.in_a = pm1; bus32.in_b = pm1; bus32.in_tag = 4'd4; bus32.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus1.in_valid = 1'b0;  bus1.in_a = all_ones;  bus1.in_b = all_ones;
    bus32.in_valid = 1'b0; bus32.in_a = all_ones; bus32.in_b = all_ones;
    lat = 0;
    while (bus32.out_valid !== 1'b1 && lat < 400) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput("dw32_lat", 256'(lat), 256'(num_digits(32) + 1));
    checkPm1("dw32_value", bus32.out_value);
    checkOutput("dw32_tag", 256'(bus32.out_tag), 256'd4);
    while (bus1.out_valid !== 1'b1 && lat < 400) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checkOutput("dw1_lat", 256'(lat), 256'd256);
    checkPm1("dw1_value", bus1.out_value);
    checkOutput("dw1_tag", 256'(bus1.out_tag), 256'd2);
    checkOutput("dw32_held", 256'(bus32.out_valid), 256'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
